// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and a
// parity helper used when the receiver is built with UART_RX_PARITY_EN.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic parity_mismatch(input logic [UART_DATA_BITS-1:0] data,
                                           input logic parity_bit);
    return ^{data, parity_bit};
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-stage synchroniser for an asynchronous line that idles high.
// Every stage resets to 1 so a reset never looks like a start bit.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clock) begin
    if (reset) chain_q <= '1;
    else       chain_q <= {chain_q[STAGES-2:0], d_i};
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling and a one-entry
// output register. Optional even parity (11-bit frame) is compiled in with
// the UART_RX_PARITY_EN macro, which also adds the parity_error port.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// RX_IDLE    | waiting for a falling edge (re-armed by a high sample)
// RX_START   | confirming the start bit at its middle
// RX_DATA    | sampling 8 data bits LSB-first at mid-bit
// RX_PARITY  | sampling the even-parity bit (parity build only)
// RX_STOP    | sampling the stop bit, then handing the byte to the output
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      uart_tick,
  input  logic                      rx_signal,
  input  logic                      rx_read,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      frame_error,
  output logic                      overrun,
  output logic                      busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                      parity_error
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);

  logic                      rx_sync;
  rx_state_e                 state_q;
  logic [TW-1:0]             tick_cnt_q;
  logic [BW-1:0]             bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      armed_q;
  logic                      busy_q;
  logic                      commit_q;
  logic                      ferr_pend_q;
  logic [UART_DATA_BITS-1:0] rx_data_q;
  logic                      rx_valid_q;
  logic                      frame_error_q;
  logic                      overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                      perr_flag_q;
  logic                      perr_pend_q;
  logic                      parity_error_q;
`endif

  uart_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d_i  (rx_signal),
    .q_o  (rx_sync)
  );

  // Frame FSM: advances only on uart_tick; raises one-cycle commit/error
  // requests that the output register acts on the following clock.
  // armed_q blocks a new start until the line has been seen high, so a
  // held-low line (break) yields a single framing error.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RX_IDLE;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      commit_q    <= 1'b0;
      ferr_pend_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_flag_q <= 1'b0;
      perr_pend_q <= 1'b0;
`endif
    end else begin
      commit_q    <= 1'b0;
      ferr_pend_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_pend_q <= 1'b0;
`endif
      if (uart_tick) begin
        case (state_q)
          RX_IDLE: begin
            if (!armed_q) begin
              if (rx_sync) armed_q <= 1'b1;
            end else if (!rx_sync) begin
              state_q    <= RX_START;
              tick_cnt_q <= '0;
              busy_q     <= 1'b1;
            end
          end
          RX_START: begin
            if (tick_cnt_q == HALF_LAST) begin
              tick_cnt_q <= '0;
              if (!rx_sync) begin
                state_q   <= RX_DATA;
                bit_idx_q <= '0;
              end else begin
                state_q <= RX_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          RX_DATA: begin
            if (tick_cnt_q == FULL_LAST) begin
              tick_cnt_q         <= '0;
              shift_q[bit_idx_q] <= rx_sync;
              if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state_q <= RX_PARITY;
`else
                state_q <= RX_STOP;
`endif
              end else begin
                bit_idx_q <= bit_idx_q + 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          RX_PARITY: begin
            if (tick_cnt_q == FULL_LAST) begin
              tick_cnt_q  <= '0;
              perr_flag_q <= parity_mismatch(shift_q, rx_sync);
              state_q     <= RX_STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
`endif
          RX_STOP: begin
            if (tick_cnt_q == FULL_LAST) begin
              tick_cnt_q <= '0;
              state_q    <= RX_IDLE;
              busy_q     <= 1'b0;
              if (rx_sync) begin
`ifdef UART_RX_PARITY_EN
                commit_q    <= !perr_flag_q;
                perr_pend_q <= perr_flag_q;
`else
                commit_q    <= 1'b1;
`endif
              end else begin
                // A bad stop bit outranks a parity error.
                ferr_pend_q <= 1'b1;
                armed_q     <= 1'b0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q    <= RX_IDLE;
            tick_cnt_q <= '0;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  // One-entry output register with read handshake and error pulses.
  // A commit coinciding with rx_read replaces the byte without overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      frame_error_q  <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error_q <= 1'b0;
`endif
    end else begin
      frame_error_q  <= ferr_pend_q;
      overrun_q      <= commit_q && rx_valid_q && !rx_read;
`ifdef UART_RX_PARITY_EN
      parity_error_q <= perr_pend_q;
`endif
      if (commit_q) begin
        rx_data_q  <= shift_q;
        rx_valid_q <= 1'b1;
      end else if (rx_read) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign frame_error  = frame_error_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = parity_error_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clocks, 16 ticks per bit,
// frames driven bit-accurately on the falling clock edge.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       uart_tick = 1'b0;
  logic       rx_signal = 1'b1;
  logic       rx_read = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Monitor state, sampled on the falling edge.
  int   fe_cnt = 0, fe_hi = 0, ov_cnt = 0, ov_hi = 0, pe_cnt = 0;
  logic fe_prev = 1'b0, ov_prev = 1'b0, pe_prev = 1'b0, valid_prev = 1'b0;
  logic tick_prev = 1'b0;
  logic lat_ok = 1'b0;
  int   tick_div = 0;

  uart_rx #(
    .OVERSAMPLE (16),
    .SYNC_STAGES(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .uart_tick   (uart_tick),
    .rx_signal   (rx_signal),
    .rx_read     (rx_read),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error(parity_error)
`endif
  );

  always #5 clock = ~clock;

  // Tick generator plus pulse/latency monitor.
  initial begin
    forever begin
      @(negedge clock);
      if (frame_error) fe_hi++;
      if (frame_error && !fe_prev) fe_cnt++;
      fe_prev = frame_error;
      if (overrun) ov_hi++;
      if (overrun && !ov_prev) ov_cnt++;
      ov_prev = overrun;
`ifdef UART_RX_PARITY_EN
      if (parity_error && !pe_prev) pe_cnt++;
      pe_prev = parity_error;
`endif
      // rx_valid must rise on the clock right after a tick edge.
      if (rx_valid && !valid_prev) lat_ok = tick_prev && !uart_tick;
      valid_prev = rx_valid;
      tick_prev  = uart_tick;
      tick_div   = (tick_div + 1) % 4;
      uart_tick  = (tick_div == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    fe_cnt = 0; fe_hi = 0; ov_cnt = 0; ov_hi = 0; pe_cnt = 0; lat_ok = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    rx_signal = b;
    repeat (BIT_CLKS) @(negedge clock);
  endtask

  task automatic idle_bits(input int n);
    rx_signal = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^data);
`endif
    drive_bit(stop_bit);
    rx_signal = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] data, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(par);
    drive_bit(1'b1);
  endtask
`endif

  task automatic pulse_read();
    rx_read = 1'b1;
    @(negedge clock);
    rx_read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic timed_out;
    timed_out = 1'b0;

    // Reset values
    repeat (5) @(negedge clock);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_error", 32'(frame_error), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle_bits(1);

    // Clean frame 0xA5
    clear_mon();
    send_frame(8'hA5, 1'b1);
    idle_bits(1);
    check("a5_rx_data", 32'(rx_data), 32'hA5);
    check("a5_rx_valid", 32'(rx_valid), 32'd1);
    check("a5_latency", 32'(lat_ok), 32'd1);
    check("a5_frame_error", 32'(fe_cnt), 32'd0);
    check("a5_overrun", 32'(ov_cnt), 32'd0);
    check("a5_busy_idle", 32'(busy), 32'd0);
    pulse_read();
    check("a5_read_clears", 32'(rx_valid), 32'd0);
    pulse_read();
    check("read_when_empty", 32'(rx_valid), 32'd0);

    // Start-bit glitch, low for 4 ticks
    clear_mon();
    rx_signal = 1'b0;
    repeat (12) @(negedge clock);
    check("glitch_busy_start", 32'(busy), 32'd1);
    repeat (4) @(negedge clock);
    idle_bits(3);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_rx_valid", 32'(rx_valid), 32'd0);
    check("glitch_frame_error", 32'(fe_cnt), 32'd0);
    check("glitch_rx_data", 32'(rx_data), 32'hA5);

    // Frame 0x3C with a low stop bit, from a fresh reset
    do_reset();
    idle_bits(1);
    clear_mon();
    send_frame(8'h3C, 1'b0);
    idle_bits(1);
    check("ferr_pulses", 32'(fe_cnt), 32'd1);
    check("ferr_width", 32'(fe_hi), 32'd1);
    check("ferr_rx_valid", 32'(rx_valid), 32'd0);
    check("ferr_rx_data", 32'(rx_data), 32'h00);

    // Back-to-back 0x12, 0x34 with no read
    clear_mon();
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    idle_bits(1);
    check("b2b_rx_data", 32'(rx_data), 32'h34);
    check("b2b_rx_valid", 32'(rx_valid), 32'd1);
    check("b2b_overrun_pulses", 32'(ov_cnt), 32'd1);
    check("b2b_overrun_width", 32'(ov_hi), 32'd1);

    // Back-to-back again, reading on the second byte's write clock
    pulse_read();
    clear_mon();
    send_frame(8'h12, 1'b1);
    fork
      send_frame(8'h34, 1'b1);
      begin
        int n;
        n = 0;
        while (!busy && n < 300) begin @(negedge clock); n++; end
        if (!busy) timed_out = 1'b1;
        n = 0;
        while (busy && n < 900) begin @(negedge clock); n++; end
        if (busy) timed_out = 1'b1;
        pulse_read();
        check("rdcol_rx_valid", 32'(rx_valid), 32'd1);
        check("rdcol_rx_data", 32'(rx_data), 32'h34);
      end
    join
    idle_bits(1);
    check("rdcol_timeout", 32'(timed_out), 32'd0);
    check("rdcol_overrun", 32'(ov_cnt), 32'd0);
    check("rdcol_valid_after", 32'(rx_valid), 32'd1);

    // Reset during DATA after three bits, then a clean 0x5A
    clear_mon();
    fork
      send_frame(8'hF8, 1'b1);
      begin
        repeat (4 * BIT_CLKS + 32) @(negedge clock);
        check("midrst_busy_before", 32'(busy), 32'd1);
        do_reset();
        check("midrst_rx_valid", 32'(rx_valid), 32'd0);
        check("midrst_rx_data", 32'(rx_data), 32'h00);
        check("midrst_busy", 32'(busy), 32'd0);
      end
    join
    idle_bits(1);
    check("midrst_no_byte", 32'(rx_valid), 32'd0);
    send_frame(8'h5A, 1'b1);
    idle_bits(1);
    check("midrst_5a_data", 32'(rx_data), 32'h5A);
    check("midrst_5a_valid", 32'(rx_valid), 32'd1);
    check("midrst_5a_latency", 32'(lat_ok), 32'd1);
    check("midrst_errors", 32'(fe_cnt + ov_cnt), 32'd0);

    // Break: line held low for 12 bit times
    pulse_read();
    clear_mon();
    rx_signal = 1'b0;
    repeat (12 * BIT_CLKS) @(negedge clock);
    check("break_ferr", 32'(fe_cnt), 32'd1);
    check("break_idle", 32'(busy), 32'd0);
    check("break_rx_valid", 32'(rx_valid), 32'd0);
    idle_bits(2);
    send_frame(8'h81, 1'b1);
    idle_bits(1);
    check("break_recover_data", 32'(rx_data), 32'h81);
    check("break_recover_valid", 32'(rx_valid), 32'd1);
    check("break_ferr_total", 32'(fe_cnt), 32'd1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity needs a parity bit of 1
    pulse_read();
    clear_mon();
    send_frame_par(8'h07, 1'b0);
    idle_bits(1);
    check("par_bad_pulse", 32'(pe_cnt), 32'd1);
    check("par_bad_valid", 32'(rx_valid), 32'd0);
    check("par_bad_data", 32'(rx_data), 32'h81);
    clear_mon();
    send_frame_par(8'h07, 1'b1);
    idle_bits(1);
    check("par_good_data", 32'(rx_data), 32'h07);
    check("par_good_valid", 32'(rx_valid), 32'd1);
    check("par_good_nopulse", 32'(pe_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
